// File: rtl/rsh_seq_ctrl_if.sv
// rtl/rsh_seq_ctrl_if.sv - requester/result bundle for the multi-cycle right-shift sequencer
//
// Signals:
//   req0/data0/amt0   requester 0 request, operand (2**N bits), shift distance (N bits)
//   req1/data1/amt1   requester 1 request, operand, shift distance
//   gnt0/gnt1         one-cycle grant pulses, operands captured
//   busy              sequencer not idle
//   done              one-cycle pulse, result valid
//   done_id           requester owning the current/last result
//   result            shifted value, held until the next done
// Modports: master = requester side, slave = sequencer side.

interface rsh_seq_ctrl_if #(
    parameter int N = 4
);
    localparam int W = 2 ** N;

    logic         req0;
    logic [W-1:0] data0;
    logic [N-1:0] amt0;
    logic         req1;
    logic [W-1:0] data1;
    logic [N-1:0] amt1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] result;

    modport master (
        output req0, data0, amt0, req1, data1, amt1,
        input  gnt0, gnt1, busy, done, done_id, result
    );

    modport slave (
        input  req0, data0, amt0, req1, data1, amt1,
        output gnt0, gnt1, busy, done, done_id, result
    );
endinterface

// File: rtl/rsh_seq_ctrl.sv
// rtl/rsh_seq_ctrl.sv - round-robin arbitrated multi-cycle logical right-shift sequencer
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rsh_seq_ctrl_if.slave: two requesters in, grants/busy/done/result out
// One single-bit shift is applied per SHIFT cycle; done is high in the cycle
// C(1+amt) after the capture edge, including amt = 0.

module rsh_seq_ctrl #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    rsh_seq_ctrl_if.slave   bus
);
    localparam int W = 2 ** N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [W-1:0] rsh_one(input logic [W-1:0] v);
        return {1'b0, v[W-1:1]};
    endfunction

    state_t       state;
    state_t       state_next;
    logic [W-1:0] sreg;
    logic [W-1:0] sreg_next;
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_next;
    logic [N-1:0] amt_sel;
    logic         owner;
    logic         last;
    logic         win1;
    logic         capture;
    logic         gnt0_r;
    logic         gnt1_r;
    logic         done_id_r;
    logic [W-1:0] result_r;

    always_comb begin
        state_next = state;
        sreg_next  = sreg;
        cnt_next   = cnt;
        capture    = 1'b0;
        // Requester 1 wins if it is alone, or on a tie when requester 0 was granted last.
        win1       = bus.req1 && (!bus.req0 || !last);
        amt_sel    = win1 ? bus.amt1 : bus.amt0;

        case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    capture    = 1'b1;
                    sreg_next  = win1 ? bus.data1 : bus.data0;
                    cnt_next   = amt_sel;
                    state_next = (amt_sel != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                sreg_next = rsh_one(sreg);
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end
                if (cnt <= 1) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done_id_r <= 1'b0;
            result_r  <= '0;
        end else begin
            state  <= state_next;
            sreg   <= sreg_next;
            cnt    <= cnt_next;
            gnt0_r <= capture && !win1;
            gnt1_r <= capture && win1;
            if (capture) begin
                owner <= win1;
                last  <= win1;
            end
            // Result is loaded on entry to DONE so it is valid alongside done
            // and then holds until the next completion.
            if (state_next == S_DONE) begin
                result_r  <= sreg_next;
                done_id_r <= capture ? win1 : owner;
            end
        end
    end

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE);
    assign bus.done_id = done_id_r;
    assign bus.result  = result_r;
endmodule

// File: tb/tb_rsh_seq_ctrl.sv
// tb/tb_rsh_seq_ctrl.sv - table-driven and directed checks for rsh_seq_ctrl

module tb_rsh_seq_ctrl;
    localparam int N = 4;

    logic clk;
    logic rst;

    rsh_seq_ctrl_if #(.N(N)) bus ();

    rsh_seq_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] d0;
        logic [3:0]  a0;
        logic [15:0] d1;
        logic [3:0]  a1;
        logic        exp_id;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];
    int   n_vec;
    int   n_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 40) begin
            tick();
            k++;
        end
        check("wait_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bus.req0  = v.r0;
        bus.req1  = v.r1;
        bus.data0 = v.d0;
        bus.amt0  = v.a0;
        bus.data1 = v.d1;
        bus.amt1  = v.a1;
        tick();
        check($sformatf("v%0d_gnt", idx), {30'd0, bus.gnt1, bus.gnt0},
              v.exp_id ? 32'd2 : 32'd1);
        check($sformatf("v%0d_busy_c1", idx), {31'd0, bus.busy}, 32'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
            if (!bus.done) begin
                check($sformatf("v%0d_busy_mid", idx), {31'd0, bus.busy}, 32'd1);
            end
        end
        check($sformatf("v%0d_lat", idx), lat, v.exp_lat);
        check($sformatf("v%0d_res", idx), {16'd0, bus.result}, {16'd0, v.exp_res});
        check($sformatf("v%0d_id", idx), {31'd0, bus.done_id}, {31'd0, v.exp_id});
        tick();
        check($sformatf("v%0d_busy_after", idx), {30'd0, bus.busy, bus.done}, 32'd0);
        check($sformatf("v%0d_res_hold", idx), {16'd0, bus.result}, {16'd0, v.exp_res});
    endtask

    initial begin
        int   g_id   [4];
        int   g_cyc  [4];
        int   d_id   [4];
        int   d_res  [4];
        int   ng;
        int   nd;
        int   cyc;
        int   dones;
        int   gap;
        logic [15:0] rr_exp [2];

        n_vec = 0;
        n_err = 0;

        //          r0    r1    d0        a0  d1        a1  id    res       lat
        vecs[0] = '{1'b1, 1'b1, 16'hF0F0, 4,  16'h5555, 7,  1'b0, 16'h0F0F, 4};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 0,  16'hABCD, 0,  1'b1, 16'hABCD, 0};
        vecs[2] = '{1'b1, 1'b0, 16'h8000, 15, 16'h0000, 0,  1'b0, 16'h0001, 15};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 3,  16'h1234, 8,  1'b1, 16'h0012, 8};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 3,  16'h1234, 8,  1'b0, 16'h1FFF, 3};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 0,  16'h8001, 1,  1'b1, 16'h4000, 1};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 0,  16'hFFFF, 15, 1'b1, 16'h0001, 15};
        vecs[7] = '{1'b1, 1'b0, 16'h0001, 0,  16'h0000, 0,  1'b0, 16'h0001, 0};

        // Reset held two cycles with both requests high: nothing may be granted.
        rst       = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = '0;
        bus.amt0  = '0;
        bus.data1 = '0;
        bus.amt1  = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst%0d_outs", i),
                  {26'd0, bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, 1'b0},
                  32'd0);
            check($sformatf("rst%0d_result", i), {16'd0, bus.result}, 32'd0);
        end
        rst = 1'b0;

        // Table: the first vector is the post-reset tie, which must go to requester 0.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Round-robin with both requests held continuously, amt = 2.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 16'h00F0;
        bus.amt0  = 4'd2;
        bus.data1 = 16'h0F00;
        bus.amt1  = 4'd2;
        rr_exp[0] = 16'h003C;
        rr_exp[1] = 16'h03C0;
        ng  = 0;
        nd  = 0;
        cyc = 0;
        while (nd < 4 && cyc < 60) begin
            tick();
            cyc++;
            if ((bus.gnt0 || bus.gnt1) && ng < 4) begin
                g_id[ng]  = bus.gnt1 ? 1 : 0;
                g_cyc[ng] = cyc;
                ng++;
            end
            if (bus.done) begin
                d_id[nd]  = bus.done_id ? 1 : 0;
                d_res[nd] = int'(bus.result);
                nd++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("rr_grants", ng, 4);
        check("rr_dones", nd, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_gnt_id%0d", i), (i < ng) ? g_id[i] : -1, i % 2);
            check($sformatf("rr_done_id%0d", i), (i < nd) ? d_id[i] : -1, i % 2);
            check($sformatf("rr_res%0d", i), (i < nd) ? d_res[i] : -1,
                  {16'd0, rr_exp[i % 2]});
        end
        for (int i = 1; i < 4; i++) begin
            gap = (i < ng) ? g_cyc[i] - g_cyc[i-1] : -1;
            check($sformatf("rr_gap%0d", i), gap, 4);
        end
        wait_idle();

        // Reset in C4 of an amt = 10 operation: no done, result cleared.
        bus.req0  = 1'b1;
        bus.data0 = 16'hFFFF;
        bus.amt0  = 4'd10;
        tick();
        check("abort_gnt0", {31'd0, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {30'd0, bus.busy, bus.done}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 16'hC3C3, 2, 16'h0000, 0, 1'b0, 16'h30F0, 2};
            run_vec(v, 8);
        end

        // Held request: req1 stays high, second grant three cycles after the first.
        bus.req1  = 1'b1;
        bus.data1 = 16'h0002;
        bus.amt1  = 4'd1;
        tick();
        check("held_gnt1_first", {31'd0, bus.gnt1}, 32'd1);
        cyc   = 0;
        dones = 0;
        do begin
            tick();
            cyc++;
            if (bus.done) begin
                dones++;
                check("held_res", {16'd0, bus.result}, 32'h0001);
                check("held_done_id", {31'd0, bus.done_id}, 32'd1);
            end
        end while (!bus.gnt1 && cyc < 20);
        bus.req1 = 1'b0;
        check("held_gap", cyc, 3);
        check("held_dones", dones, 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
